// File: rtl/hc_sr_pkg.sv
// Shared types and defaults for the HC-SR04 trigger sequencer.
// Holds the sequencer state encoding, sweep mode codes and timing defaults.
package hc_sr_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      GAP
   } hc_sr_state_e;

   localparam logic MODE_CONT   = 1'b0;
   localparam logic MODE_SINGLE = 1'b1;

   localparam int TRIG_US_DEF = 10;
   localparam int SLOT_US_DEF = 60000;

endpackage

// File: rtl/hc_sr_echo_sync.sv
// One echo pin: 2-flop synchroniser plus edge detect on the synchronised level.
// The synchronised level lags the pin by two cycles; edges are flagged in the cycle the level changes.
module hc_sr_echo_sync (
   input  logic clk_us,
   input  logic Rst_n,
   input  logic echo,
   output logic echo_lvl,
   output logic echo_rise,
   output logic echo_fall
);

   logic sync_p0;
   logic sync_p1;
   logic sync_p2;

   always_ff @(posedge clk_us or negedge Rst_n) begin
      if (!Rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         sync_p2 <= 1'b0;
      end else begin
         sync_p0 <= echo;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
      end
   end

   assign echo_lvl  = sync_p1;
   assign echo_rise = sync_p1 & ~sync_p2;
   assign echo_fall = ~sync_p1 & sync_p2;

endmodule

// File: rtl/hc_sr_trig_seq.sv
// Round-robin HC-SR04 trigger sequencer: one slot per channel, fires trig, then times the echo.
// Emits one registered result per channel per completed slot (width in us or timeout).
module hc_sr_trig_seq
   import hc_sr_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int CH_W    = 2,
   parameter int TRIG_US = TRIG_US_DEF,
   parameter int SLOT_US = SLOT_US_DEF,
   parameter int CNT_W   = 16
) (
   input  logic              clk_us,
   input  logic              Rst_n,
   input  logic              en,
   input  logic              mode,
   input  logic              start,
   input  logic [N_CH-1:0]   echo,
   output logic [N_CH-1:0]   trig,
   output logic              busy,
   output logic              meas_vld,
   output logic [CH_W-1:0]   meas_ch,
   output logic [CNT_W-1:0]  meas_us,
   output logic              meas_timeout
);

   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_US - 1);
   localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

   hc_sr_state_e      state;
   logic [CNT_W-1:0]  slot_cnt;
   logic [CNT_W-1:0]  width;
   logic [CH_W-1:0]   ch;

   logic [N_CH-1:0]   echo_lvl;
   logic [N_CH-1:0]   echo_rise;
   logic [N_CH-1:0]   echo_fall;
   logic              sel_lvl;
   logic              sel_rise;
   logic              sel_fall;
   logic              slot_end;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   function automatic logic [N_CH-1:0] ch_onehot(input logic [CH_W-1:0] c);
      logic [N_CH-1:0] r;
      for (int i = 0; i < N_CH; i++) begin
         r[i] = (c == CH_W'(i));
      end
      return r;
   endfunction

   for (genvar g = 0; g < N_CH; g++) begin : g_sync
      hc_sr_echo_sync u_sync (
         .clk_us    (clk_us),
         .Rst_n     (Rst_n),
         .echo      (echo[g]),
         .echo_lvl  (echo_lvl[g]),
         .echo_rise (echo_rise[g]),
         .echo_fall (echo_fall[g])
      );
   end

   assign sel_lvl  = echo_lvl[ch];
   assign sel_rise = echo_rise[ch];
   assign sel_fall = echo_fall[ch];
   assign slot_end = (slot_cnt == SLOT_LAST);

   always_ff @(posedge clk_us or negedge Rst_n) begin
      if (!Rst_n) begin
         state        <= IDLE;
         slot_cnt     <= '0;
         width        <= '0;
         ch           <= '0;
         trig         <= '0;
         busy         <= 1'b0;
         meas_vld     <= 1'b0;
         meas_ch      <= '0;
         meas_us      <= '0;
         meas_timeout <= 1'b0;
      end else begin
         meas_vld <= 1'b0;
         if (state == IDLE) begin
            slot_cnt <= '0;
            if (en && (mode == MODE_CONT || start)) begin
               state <= TRIG;
               ch    <= '0;
               trig  <= ch_onehot('0);
               busy  <= 1'b1;
            end
         end else if (!en) begin
            // Abort wins over any result that would have been strobed on this edge.
            state    <= IDLE;
            slot_cnt <= '0;
            ch       <= '0;
            trig     <= '0;
            busy     <= 1'b0;
         end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
            case (state)
               TRIG: begin
                  if (slot_cnt == TRIG_LAST) begin
                     trig  <= '0;
                     state <= WAIT_RISE;
                  end
               end
               WAIT_RISE: begin
                  if (sel_rise) begin
                     width <= CNT_W'(1);
                     state <= MEASURE;
                  end
                  if (slot_end) begin
                     meas_vld     <= 1'b1;
                     meas_ch      <= ch;
                     meas_us      <= sel_rise ? CNT_W'(1) : '0;
                     meas_timeout <= 1'b1;
                  end
               end
               MEASURE: begin
                  if (sel_fall) begin
                     meas_vld     <= 1'b1;
                     meas_ch      <= ch;
                     meas_us      <= width;
                     meas_timeout <= 1'b0;
                     state        <= GAP;
                  end else begin
                     if (sel_lvl) begin
                        width <= sat_inc(width);
                     end
                     if (slot_end) begin
                        meas_vld     <= 1'b1;
                        meas_ch      <= ch;
                        meas_us      <= sel_lvl ? sat_inc(width) : width;
                        meas_timeout <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
            // Slot boundary overrides the per-state next state chosen above.
            if (slot_end) begin
               if (ch != CH_LAST) begin
                  ch    <= CH_W'(ch + 1'b1);
                  state <= TRIG;
                  trig  <= ch_onehot(CH_W'(ch + 1'b1));
               end else if (mode == MODE_CONT) begin
                  ch    <= '0;
                  state <= TRIG;
                  trig  <= ch_onehot('0);
               end else begin
                  ch    <= '0;
                  state <= IDLE;
                  trig  <= '0;
                  busy  <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_hc_sr_trig_seq.sv
// Directed bench for hc_sr_trig_seq with N_CH=2, TRIG_US=10, SLOT_US=100.
// Expected results are queued when stimulus is planned and compared on every meas_vld.
module tb_hc_sr_trig_seq;
   import hc_sr_pkg::*;

   localparam int N_CH    = 2;
   localparam int CH_W    = 1;
   localparam int TRIG_US = 10;
   localparam int SLOT_US = 100;
   localparam int CNT_W   = 16;

   logic              clk_us = 1'b0;
   logic              Rst_n  = 1'b0;
   logic              en     = 1'b0;
   logic              mode   = 1'b0;
   logic              start  = 1'b0;
   logic [N_CH-1:0]   echo   = '0;
   logic [N_CH-1:0]   trig;
   logic              busy;
   logic              meas_vld;
   logic [CH_W-1:0]   meas_ch;
   logic [CNT_W-1:0]  meas_us;
   logic              meas_timeout;

   typedef struct packed {
      logic [CH_W-1:0]  ch;
      logic [CNT_W-1:0] us;
      logic             to;
   } res_t;

   res_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk_us = ~clk_us;

   hc_sr_trig_seq #(
      .N_CH    (N_CH),
      .CH_W    (CH_W),
      .TRIG_US (TRIG_US),
      .SLOT_US (SLOT_US),
      .CNT_W   (CNT_W)
   ) dut (
      .clk_us       (clk_us),
      .Rst_n        (Rst_n),
      .en           (en),
      .mode         (mode),
      .start        (start),
      .echo         (echo),
      .trig         (trig),
      .busy         (busy),
      .meas_vld     (meas_vld),
      .meas_ch      (meas_ch),
      .meas_us      (meas_us),
      .meas_timeout (meas_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_us);
      #1;
   endtask

   // Slots repeat every SLOT_US cycles alternating ch0/ch1; nothing fires from end_c on.
   function automatic logic [1:0] exp_trig(input int c, input int end_c);
      if (c >= end_c) return 2'b00;
      if ((c % SLOT_US) < TRIG_US) return 2'b01 << ((c / SLOT_US) % 2);
      return 2'b00;
   endfunction

   task automatic cyc(input int c, input int end_c);
      chk("trig", {30'd0, trig}, {30'd0, exp_trig(c, end_c)});
      chk("busy", {31'd0, busy}, {31'd0, (c < end_c)});
      tick();
   endtask

   task automatic start_sweep(input logic m);
      mode  = m;
      en    = 1'b1;
      start = m;
      tick();
      start = 1'b0;
   endtask

   task automatic push(input int c, input int us, input logic to);
      res_t r;
      r.ch = CH_W'(c);
      r.us = CNT_W'(us);
      r.to = to;
      exp_q.push_back(r);
   endtask

   always @(negedge clk_us) begin
      res_t r;
      if (Rst_n && meas_vld) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_strobe: observed ch=%0d us=%0d to=%0b, expected no strobe",
                   meas_ch, meas_us, meas_timeout);
         end
         if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk("meas_ch", {31'd0, meas_ch}, {31'd0, r.ch});
            chk("meas_us", {16'd0, meas_us}, {16'd0, r.us});
            chk("meas_timeout", {31'd0, meas_timeout}, {31'd0, r.to});
         end
      end
   end

   initial begin
      // Power-up reset state.
      tick();
      tick();
      chk("rst_trig", {30'd0, trig}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_vld", {31'd0, meas_vld}, 32'd0);
      chk("rst_ch", {31'd0, meas_ch}, 32'd0);
      chk("rst_us", {16'd0, meas_us}, 32'd0);
      chk("rst_to", {31'd0, meas_timeout}, 32'd0);
      Rst_n = 1'b1;
      tick();

      // Reset asserted in the middle of TRIG drops trig without a clock edge.
      start_sweep(MODE_SINGLE);
      tick();
      tick();
      tick();
      chk("pre_rst_trig", {30'd0, trig}, 32'd1);
      Rst_n = 1'b0;
      #1;
      chk("async_rst_trig", {30'd0, trig}, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      en = 1'b0;
      tick();
      tick();
      Rst_n = 1'b1;
      for (int c = 0; c < 20; c++) cyc(c, 0);

      // Single sweep: 30-cycle echo on ch0, silent ch1.
      push(0, 30, 1'b0);
      push(1, 0, 1'b1);
      start_sweep(MODE_SINGLE);
      for (int c = 0; c < 205; c++) begin
         if (c == 20) echo[0] = 1'b1;
         if (c == 50) echo[0] = 1'b0;
         cyc(c, 200);
      end
      chk("single_pending", exp_q.size(), 32'd0);
      chk("hold_ch", {31'd0, meas_ch}, 32'd1);
      chk("hold_to", {31'd0, meas_timeout}, 32'd1);

      // Stuck-high echo on ch0 reports the width accumulated up to slot end.
      push(0, 78, 1'b1);
      push(1, 0, 1'b1);
      start_sweep(MODE_SINGLE);
      for (int c = 0; c < 205; c++) begin
         if (c == 20) echo[0] = 1'b1;
         cyc(c, 200);
      end
      echo[0] = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("stuck_pending", exp_q.size(), 32'd0);

      // Drop en on the last slot cycle: the timeout strobe due on that edge is suppressed.
      start_sweep(MODE_SINGLE);
      for (int c = 0; c < 105; c++) begin
         if (c == 99) en = 1'b0;
         cyc(c, 100);
      end

      // Continuous sweep aborted during the second pass over ch0.
      push(0, 0, 1'b1);
      push(1, 0, 1'b1);
      start_sweep(MODE_CONT);
      for (int c = 0; c < 260; c++) begin
         if (c == 250) en = 1'b0;
         cyc(c, 251);
      end
      chk("cont_a_pending", exp_q.size(), 32'd0);

      // Continuous sweep run long enough to see trig at 0,100,200,300,400.
      push(0, 0, 1'b1);
      push(1, 0, 1'b1);
      push(0, 0, 1'b1);
      push(1, 0, 1'b1);
      start_sweep(MODE_CONT);
      for (int c = 0; c < 420; c++) begin
         if (c == 410) en = 1'b0;
         cyc(c, 411);
      end
      chk("cont_b_pending", exp_q.size(), 32'd0);

      // Echo edges in TRIG and GAP are ignored; start while busy does not re-arm.
      push(0, 15, 1'b0);
      push(1, 25, 1'b0);
      start_sweep(MODE_SINGLE);
      for (int c = 0; c < 260; c++) begin
         case (c)
            2:   echo[0] = 1'b1;
            6:   echo[0] = 1'b0;
            30:  echo[0] = 1'b1;
            45:  echo[0] = 1'b0;
            50:  start   = 1'b1;
            51:  start   = 1'b0;
            70:  echo[0] = 1'b1;
            80:  echo[0] = 1'b0;
            150: echo[1] = 1'b1;
            175: echo[1] = 1'b0;
            default: ;
         endcase
         cyc(c, 200);
      end
      chk("ignore_pending", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hc_sr_trig_seq.md
Name: hc_sr_trig_seq

Overview:
N-channel HC-SR04 trigger sequencer with echo-width capture, clocked by the 1 MHz tick clock (1 cycle = 1 us).
- Fires channels round-robin, one time slot each, so transducers do not crosstalk.
- Measures each channel's echo high time in us and reports one result per channel per sweep.
- Runs in continuous or single-sweep mode.
- Sits between the sensor pins and the distance-conversion/display logic.

Parameters:
N_CH, 4, number of sensor channels (1..16)
CH_W, 2, width of channel index; must satisfy 2^CH_W >= N_CH
TRIG_US, 10, trig high time in clk_us cycles (>= 1)
SLOT_US, 60000, slot length in cycles; must be > TRIG_US + 4
CNT_W, 16, width of slot counter and meas_us; 2^CNT_W > SLOT_US

Ports:
clk_us  in  1  system clock 1 MHz
Rst_n  in  1  asynchronous reset, active low
en  in  1  enable; low aborts any sweep
mode  in  1  0 = continuous sweeps, 1 = single sweep per start
start  in  1  single-sweep request (level sampled, used only when mode=1 and idle)
echo  in  N_CH  raw echo pins, asynchronous
trig  out  N_CH  trigger pulses, registered, at most one bit high
busy  out  1  high while a sweep is in progress
meas_vld  out  1  one-cycle result strobe
meas_ch  out  CH_W  channel of current result
meas_us  out  CNT_W  echo high time in cycles
meas_timeout  out  1  result is a timeout (no echo, or echo still high at slot end)

Behaviour:
- Reset: trig=0, busy=0, meas_vld=0, meas_ch=0, meas_us=0, meas_timeout=0, FSM=IDLE, slot_cnt=0, ch=0, sync flops=0.
- Echo path: 2-flop synchroniser per channel plus rise/fall detect on the synchronised signal. Latency is 2 cycles; measured width equals input width.
- slot_cnt runs 0..SLOT_US-1 in every non-IDLE state and clears on slot entry. Slot cycle k means slot_cnt == k.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, GAP.
- IDLE -> TRIG:
  - when en=1 and mode=0; or
  - when en=1, mode=1 and start=1.
  - ch := 0, busy rises on the same edge.
- TRIG: trig[ch]=1 for slot cycles 0..TRIG_US-1 exactly (TRIG_US cycles). At cycle TRIG_US-1 go to WAIT_RISE. Echo edges in TRIG are ignored.
- WAIT_RISE: on sync rise of echo[ch], clear width counter and go to MEASURE.
- MEASURE: width counter increments each cycle sync echo[ch]=1; it saturates at 2^CNT_W-1. On sync fall, pulse meas_vld the next cycle with meas_us=width, meas_timeout=0, meas_ch=ch, then go to GAP.
- Timeout: if slot cycle SLOT_US-1 is reached in WAIT_RISE or MEASURE, pulse meas_vld the next cycle with meas_timeout=1 and meas_us = width so far (0 if no rise).
- GAP: idle until slot end. Echo edges in GAP are ignored.
- Slot end (cycle SLOT_US-1):
  - if ch < N_CH-1: ch+1, TRIG;
  - else mode=0 -> ch=0, TRIG; mode=1 -> IDLE, busy falls.
- Timeout and slot-end transition coincide; the timeout result for ch is still emitted, one cycle after the edge.
- Exactly one meas_vld per channel per completed slot. meas_ch/meas_us/meas_timeout hold their value until the next strobe.
- en=0 in any non-IDLE state: next edge -> IDLE, trig=0, busy=0, no meas_vld for the aborted slot. A strobe already scheduled on that same edge is also suppressed.
- start while busy, or start with mode=0: ignored. mode changes take effect only at sweep end.
- Reset mid-sweep: immediate return to reset values, trig low asynchronously.

Decomposition:
- Package hc_sr_pkg:
  - state enum (IDLE/TRIG/WAIT_RISE/MEASURE/GAP);
  - MODE_CONT=0, MODE_SINGLE=1;
  - default TRIG_US/SLOT_US constants.
- Sub-module hc_sr_echo_sync: 1-bit 2-flop synchroniser with rise/fall outputs, instantiated N_CH times.

Test Plan:
All scenarios use N_CH=2, TRIG_US=10, SLOT_US=100, CNT_W=16.
- Reset: assert Rst_n=0 mid-TRIG -> trig=0 immediately; all outputs 0; no strobe after release while en=0.
- Single sweep: mode=1, start pulse; echo[0] high 30 cycles starting at slot cycle 20; echo[1] never rises.
  - trig[0] high cycles 0..9, trig[1] high 10 cycles starting 100 cycles later.
  - Results: meas_ch=0/meas_us=30/timeout=0, then meas_ch=1/meas_us=0/timeout=1.
  - busy low after 200 cycles.
- Stuck echo: echo[0] rises at input slot cycle 20 and never falls -> strobe after slot end with meas_timeout=1, meas_us=78 (sync-high cycles 22..99).
- Continuous: mode=0, en=1 -> trig[0] at cycles 0, 200, 400; trig[1] at 100, 300. Drop en at cycle 250 -> trig all 0 and busy 0 next cycle, no strobe for ch0 of that sweep.
- Ignored edges: echo[0] pulse during cycles 2..5 (TRIG) plus a second pulse in GAP -> only the legal pulse is reported, width exact; one strobe per slot.
- start while busy (cycle 50) -> no extra sweep; exactly 2 strobes total.
